// File: rtl/id_ex_ctrl_pipe.sv
// id_ex_ctrl_pipe: control-side pipeline registers for EX, MEM and WB.
// Carries the decoder outputs downstream and detects load-use hazards
// against the instruction currently in ID. It also counts the
// instructions that reach WB.
module id_ex_ctrl_pipe #(
  parameter int DSEL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_id,
  input  logic              ImmID,
  input  logic [2:0]        SID,
  input  logic              CinID,
  input  logic              SWID,
  input  logic              LWID,
  input  logic [DSEL_W-1:0] dsel_id,
  input  logic [DSEL_W-1:0] rs_id,
  input  logic [DSEL_W-1:0] rt_id,
  input  logic              flush,
  output logic              ImmEX,
  output logic [2:0]        SEX,
  output logic              CinEX,
  output logic              SWEX,
  output logic              LWEX,
  output logic              valid_ex,
  output logic [DSEL_W-1:0] dsel_ex,
  output logic              SWMEM,
  output logic              LWMEM,
  output logic              valid_mem,
  output logic [DSEL_W-1:0] dsel_mem,
  output logic              wb_en,
  output logic [DSEL_W-1:0] dsel_wb,
  output logic              load_use,
  output logic [CNT_W-1:0]  retired
);

  // EX stage state
  logic              imm_ex_q,   imm_ex_d;
  logic [2:0]        s_ex_q,     s_ex_d;
  logic              cin_ex_q,   cin_ex_d;
  logic              sw_ex_q,    sw_ex_d;
  logic              lw_ex_q,    lw_ex_d;
  logic              valid_ex_q, valid_ex_d;
  logic [DSEL_W-1:0] dsel_ex_q,  dsel_ex_d;

  // MEM stage state
  logic              sw_mem_q,    sw_mem_d;
  logic              lw_mem_q,    lw_mem_d;
  logic              valid_mem_q, valid_mem_d;
  logic [DSEL_W-1:0] dsel_mem_q,  dsel_mem_d;

  // WB stage state and retirement counter
  logic              wb_en_q,   wb_en_d;
  logic [DSEL_W-1:0] dsel_wb_q, dsel_wb_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  // Hazard terms
  logic rs_hit;
  logic rt_hit;
  logic rt_read;
  logic hazard;
  logic take_id;

  // Load-use hazard: a load in EX whose destination is read by the ID
  // instruction. I-type non-stores do not read rt; stores read rt as data.
  // Register 0 never creates a dependency.
  always_comb begin
    rs_hit  = (rs_id == dsel_ex_q);
    rt_hit  = (rt_id == dsel_ex_q);
    rt_read = (~ImmID & ~SWID) | SWID;
    hazard  = valid_id & valid_ex_q & lw_ex_q & (dsel_ex_q != '0) &
              (rs_hit | (rt_read & rt_hit));
    take_id = valid_id & ~hazard & ~flush;
  end

  // ID->EX: capture only a real, non-stalled, non-flushed instruction;
  // everything else turns into a bubble with every field cleared.
  always_comb begin
    imm_ex_d   = 1'b0;
    s_ex_d     = 3'b000;
    cin_ex_d   = 1'b0;
    sw_ex_d    = 1'b0;
    lw_ex_d    = 1'b0;
    valid_ex_d = 1'b0;
    dsel_ex_d  = '0;
    if (take_id) begin
      imm_ex_d   = ImmID;
      s_ex_d     = SID;
      cin_ex_d   = CinID;
      sw_ex_d    = SWID;
      lw_ex_d    = LWID;
      valid_ex_d = 1'b1;
      dsel_ex_d  = dsel_id;
    end
  end

  // EX->MEM advances every cycle; a stall never freezes the back end.
  always_comb begin
    sw_mem_d    = sw_ex_q;
    lw_mem_d    = lw_ex_q;
    valid_mem_d = valid_ex_q;
    dsel_mem_d  = dsel_ex_q;
  end

  // MEM->WB: write enable suppresses stores and register 0, while every
  // valid instruction leaving MEM counts as retired (wrapping counter).
  always_comb begin
    wb_en_d   = valid_mem_q & ~sw_mem_q & (dsel_mem_q != '0);
    dsel_wb_d = dsel_mem_q;
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, valid_mem_q};
  end

  // All pipeline state; reset discards every in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm_ex_q    <= 1'b0;
      s_ex_q      <= 3'b000;
      cin_ex_q    <= 1'b0;
      sw_ex_q     <= 1'b0;
      lw_ex_q     <= 1'b0;
      valid_ex_q  <= 1'b0;
      dsel_ex_q   <= '0;
      sw_mem_q    <= 1'b0;
      lw_mem_q    <= 1'b0;
      valid_mem_q <= 1'b0;
      dsel_mem_q  <= '0;
      wb_en_q     <= 1'b0;
      dsel_wb_q   <= '0;
      retired_q   <= '0;
    end else begin
      imm_ex_q    <= imm_ex_d;
      s_ex_q      <= s_ex_d;
      cin_ex_q    <= cin_ex_d;
      sw_ex_q     <= sw_ex_d;
      lw_ex_q     <= lw_ex_d;
      valid_ex_q  <= valid_ex_d;
      dsel_ex_q   <= dsel_ex_d;
      sw_mem_q    <= sw_mem_d;
      lw_mem_q    <= lw_mem_d;
      valid_mem_q <= valid_mem_d;
      dsel_mem_q  <= dsel_mem_d;
      wb_en_q     <= wb_en_d;
      dsel_wb_q   <= dsel_wb_d;
      retired_q   <= retired_d;
    end
  end

  // Output mapping
  always_comb begin
    ImmEX     = imm_ex_q;
    SEX       = s_ex_q;
    CinEX     = cin_ex_q;
    SWEX      = sw_ex_q;
    LWEX      = lw_ex_q;
    valid_ex  = valid_ex_q;
    dsel_ex   = dsel_ex_q;
    SWMEM     = sw_mem_q;
    LWMEM     = lw_mem_q;
    valid_mem = valid_mem_q;
    dsel_mem  = dsel_mem_q;
    wb_en     = wb_en_q;
    dsel_wb   = dsel_wb_q;
    load_use  = hazard;
    retired   = retired_q;
  end

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// tb_id_ex_ctrl_pipe: directed vector bench for id_ex_ctrl_pipe, built with
// a 4-bit retirement counter so that wrap-around is reachable quickly.
module tb_id_ex_ctrl_pipe;

  localparam int DSEL_W = 5;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic       v;
    logic       imm;
    logic [2:0] s;
    logic       cin;
    logic       sw;
    logic       lw;
    logic [4:0] dsel;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       flush;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic        lu;
    logic [12:0] ex;
    logic [7:0]  mem;
    logic [5:0]  wb;
    logic [3:0]  ret;
  } vec_t;

  logic              clk;
  logic              reset;
  logic              valid_id, ImmID, CinID, SWID, LWID, flush;
  logic [2:0]        SID;
  logic [DSEL_W-1:0] dsel_id, rs_id, rt_id;
  logic              ImmEX, CinEX, SWEX, LWEX, valid_ex;
  logic [2:0]        SEX;
  logic [DSEL_W-1:0] dsel_ex, dsel_mem, dsel_wb;
  logic              SWMEM, LWMEM, valid_mem, wb_en, load_use;
  logic [CNT_W-1:0]  retired;

  logic [12:0] act_ex;
  logic [7:0]  act_mem;
  logic [5:0]  act_wb;

  int check_count = 0;
  int pass_count  = 0;

  vec_t vecs[20];

  id_ex_ctrl_pipe #(.DSEL_W(DSEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_id(valid_id), .ImmID(ImmID), .SID(SID),
    .CinID(CinID), .SWID(SWID), .LWID(LWID), .dsel_id(dsel_id), .rs_id(rs_id),
    .rt_id(rt_id), .flush(flush), .ImmEX(ImmEX), .SEX(SEX), .CinEX(CinEX),
    .SWEX(SWEX), .LWEX(LWEX), .valid_ex(valid_ex), .dsel_ex(dsel_ex),
    .SWMEM(SWMEM), .LWMEM(LWMEM), .valid_mem(valid_mem), .dsel_mem(dsel_mem),
    .wb_en(wb_en), .dsel_wb(dsel_wb), .load_use(load_use), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act_ex  = {ImmEX, SEX, CinEX, SWEX, LWEX, valid_ex, dsel_ex};
  assign act_mem = {SWMEM, LWMEM, valid_mem, dsel_mem};
  assign act_wb  = {wb_en, dsel_wb};

  function automatic stim_t st(input logic v, input logic imm, input logic [2:0] s,
                               input logic cin, input logic sw, input logic lw,
                               input logic [4:0] d, input logic [4:0] rs,
                               input logic [4:0] rt, input logic fl);
    return {v, imm, s, cin, sw, lw, d, rs, rt, fl};
  endfunction

  function automatic logic [12:0] exq(input logic imm, input logic [2:0] s, input logic cin,
                                      input logic sw, input logic lw, input logic v,
                                      input logic [4:0] d);
    return {imm, s, cin, sw, lw, v, d};
  endfunction

  function automatic logic [7:0] memq(input logic sw, input logic lw, input logic v,
                                      input logic [4:0] d);
    return {sw, lw, v, d};
  endfunction

  function automatic logic [5:0] wbq(input logic en, input logic [4:0] d);
    return {en, d};
  endfunction

  // Drive every ID-side input from one stimulus record
  task automatic applyStimulus(input stim_t s);
    valid_id = s.v;
    ImmID    = s.imm;
    SID      = s.s;
    CinID    = s.cin;
    SWID     = s.sw;
    LWID     = s.lw;
    dsel_id  = s.dsel;
    rs_id    = s.rs;
    rt_id    = s.rt;
    flush    = s.flush;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  initial begin
    stim_t idle;
    stim_t addi1;
    stim_t addi2;
    logic [3:0] wrap_exp[6];

    idle  = st(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    addi1 = st(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 1'b0);
    addi2 = st(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 5'd2, 5'd1, 5'd2, 1'b0);

    // ADDI, SUB, SW, LW then dependent R-type (stall), replay, I-type no-stall,
    // store-data hazard, flush, register 0, invalid ID, flush+stall together.
    vecs[0]  = '{st(1'b1,1'b1,3'd2,1'b0,1'b0,1'b0,5'd3,5'd1,5'd3,1'b0),   1'b0, exq(1'b1,3'd2,1'b0,1'b0,1'b0,1'b1,5'd3),  memq(1'b0,1'b0,1'b0,5'd0),  wbq(1'b0,5'd0),  4'd0};
    vecs[1]  = '{st(1'b1,1'b0,3'd3,1'b1,1'b0,1'b0,5'd4,5'd1,5'd2,1'b0),   1'b0, exq(1'b0,3'd3,1'b1,1'b0,1'b0,1'b1,5'd4),  memq(1'b0,1'b0,1'b1,5'd3),  wbq(1'b0,5'd0),  4'd0};
    vecs[2]  = '{st(1'b1,1'b1,3'd2,1'b0,1'b1,1'b0,5'd5,5'd2,5'd5,1'b0),   1'b0, exq(1'b1,3'd2,1'b0,1'b1,1'b0,1'b1,5'd5),  memq(1'b0,1'b0,1'b1,5'd4),  wbq(1'b1,5'd3),  4'd1};
    vecs[3]  = '{st(1'b1,1'b1,3'd2,1'b0,1'b0,1'b1,5'd7,5'd2,5'd7,1'b0),   1'b0, exq(1'b1,3'd2,1'b0,1'b0,1'b1,1'b1,5'd7),  memq(1'b1,1'b0,1'b1,5'd5),  wbq(1'b1,5'd4),  4'd2};
    vecs[4]  = '{st(1'b1,1'b0,3'd2,1'b0,1'b0,1'b0,5'd8,5'd1,5'd7,1'b0),   1'b1, exq(1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd0),  memq(1'b0,1'b1,1'b1,5'd7),  wbq(1'b0,5'd5),  4'd3};
    vecs[5]  = '{st(1'b1,1'b0,3'd2,1'b0,1'b0,1'b0,5'd8,5'd1,5'd7,1'b0),   1'b0, exq(1'b0,3'd2,1'b0,1'b0,1'b0,1'b1,5'd8),  memq(1'b0,1'b0,1'b0,5'd0),  wbq(1'b1,5'd7),  4'd4};
    vecs[6]  = '{st(1'b1,1'b1,3'd2,1'b0,1'b0,1'b1,5'd9,5'd1,5'd9,1'b0),   1'b0, exq(1'b1,3'd2,1'b0,1'b0,1'b1,1'b1,5'd9),  memq(1'b0,1'b0,1'b1,5'd8),  wbq(1'b0,5'd0),  4'd4};
    vecs[7]  = '{st(1'b1,1'b1,3'd2,1'b0,1'b0,1'b0,5'd9,5'd2,5'd9,1'b0),   1'b0, exq(1'b1,3'd2,1'b0,1'b0,1'b0,1'b1,5'd9),  memq(1'b0,1'b1,1'b1,5'd9),  wbq(1'b1,5'd8),  4'd5};
    vecs[8]  = '{st(1'b1,1'b1,3'd2,1'b0,1'b0,1'b1,5'd10,5'd0,5'd10,1'b0), 1'b0, exq(1'b1,3'd2,1'b0,1'b0,1'b1,1'b1,5'd10), memq(1'b0,1'b0,1'b1,5'd9),  wbq(1'b1,5'd9),  4'd6};
    vecs[9]  = '{st(1'b1,1'b1,3'd2,1'b0,1'b1,1'b0,5'd10,5'd3,5'd10,1'b0), 1'b1, exq(1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd0),  memq(1'b0,1'b1,1'b1,5'd10), wbq(1'b1,5'd9),  4'd7};
    vecs[10] = '{st(1'b1,1'b0,3'd2,1'b0,1'b0,1'b0,5'd11,5'd1,5'd2,1'b1),  1'b0, exq(1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd0),  memq(1'b0,1'b0,1'b0,5'd0),  wbq(1'b1,5'd10), 4'd8};
    vecs[11] = '{st(1'b1,1'b0,3'd2,1'b0,1'b0,1'b0,5'd0,5'd1,5'd2,1'b0),   1'b0, exq(1'b0,3'd2,1'b0,1'b0,1'b0,1'b1,5'd0),  memq(1'b0,1'b0,1'b0,5'd0),  wbq(1'b0,5'd0),  4'd8};
    vecs[12] = '{st(1'b0,1'b1,3'd7,1'b1,1'b1,1'b1,5'd31,5'd0,5'd0,1'b0),  1'b0, exq(1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd0),  memq(1'b0,1'b0,1'b1,5'd0),  wbq(1'b0,5'd0),  4'd8};
    vecs[13] = '{st(1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0),   1'b0, exq(1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd0),  memq(1'b0,1'b0,1'b0,5'd0),  wbq(1'b0,5'd0),  4'd9};
    vecs[14] = '{st(1'b1,1'b1,3'd2,1'b0,1'b0,1'b1,5'd0,5'd0,5'd0,1'b0),   1'b0, exq(1'b1,3'd2,1'b0,1'b0,1'b1,1'b1,5'd0),  memq(1'b0,1'b0,1'b0,5'd0),  wbq(1'b0,5'd0),  4'd9};
    vecs[15] = '{st(1'b1,1'b0,3'd2,1'b0,1'b0,1'b0,5'd12,5'd0,5'd0,1'b0),  1'b0, exq(1'b0,3'd2,1'b0,1'b0,1'b0,1'b1,5'd12), memq(1'b0,1'b1,1'b1,5'd0),  wbq(1'b0,5'd0),  4'd9};
    vecs[16] = '{st(1'b1,1'b1,3'd2,1'b0,1'b0,1'b1,5'd13,5'd1,5'd13,1'b0), 1'b0, exq(1'b1,3'd2,1'b0,1'b0,1'b1,1'b1,5'd13), memq(1'b0,1'b0,1'b1,5'd12), wbq(1'b0,5'd0),  4'd10};
    vecs[17] = '{st(1'b1,1'b0,3'd2,1'b0,1'b0,1'b0,5'd14,5'd13,5'd1,1'b1), 1'b1, exq(1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd0),  memq(1'b0,1'b1,1'b1,5'd13), wbq(1'b1,5'd12), 4'd11};
    vecs[18] = '{st(1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0),   1'b0, exq(1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd0),  memq(1'b0,1'b0,1'b0,5'd0),  wbq(1'b1,5'd13), 4'd12};
    vecs[19] = '{st(1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0),   1'b0, exq(1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,5'd0),  memq(1'b0,1'b0,1'b0,5'd0),  wbq(1'b0,5'd0),  4'd12};

    wrap_exp = '{4'd12, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};

    // Power-on reset state
    reset = 1'b1;
    applyStimulus(idle);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ex",       32'(act_ex),   32'd0);
    checkOutput("reset mem",      32'(act_mem),  32'd0);
    checkOutput("reset wb",       32'(act_wb),   32'd0);
    checkOutput("reset retired",  32'(retired),  32'd0);
    checkOutput("reset load_use", 32'(load_use), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven stream: hazard checked before the edge, stages after it
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].in);
      #1;
      checkOutput($sformatf("v%0d load_use", i), 32'(load_use), 32'(vecs[i].lu));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d ex", i),      32'(act_ex),  32'(vecs[i].ex));
      checkOutput($sformatf("v%0d mem", i),     32'(act_mem), 32'(vecs[i].mem));
      checkOutput($sformatf("v%0d wb", i),      32'(act_wb),  32'(vecs[i].wb));
      checkOutput($sformatf("v%0d retired", i), 32'(retired), 32'(vecs[i].ret));
    end

    // Counter wrap: four more retirements take 12 through 15 back to 0
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) applyStimulus(addi1);
      else applyStimulus(idle);
      @(posedge clk);
      #1;
      checkOutput($sformatf("wrap%0d retired", k), 32'(retired), 32'(wrap_exp[k]));
      if (k == 2) checkOutput("wrap wb", 32'(act_wb), 32'(wbq(1'b1, 5'd1)));
    end

    // Mid-cycle asynchronous reset with EX, MEM and WB all occupied
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      applyStimulus(addi2);
      @(posedge clk);
    end
    #1;
    checkOutput("prereset ex",      32'(act_ex),  32'(exq(1'b1,3'd2,1'b0,1'b0,1'b0,1'b1,5'd2)));
    checkOutput("prereset wb",      32'(act_wb),  32'(wbq(1'b1, 5'd2)));
    checkOutput("prereset retired", 32'(retired), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset ex",       32'(act_ex),   32'd0);
    checkOutput("async reset mem",      32'(act_mem),  32'd0);
    checkOutput("async reset wb",       32'(act_wb),   32'd0);
    checkOutput("async reset retired",  32'(retired),  32'd0);
    checkOutput("async reset load_use", 32'(load_use), 32'd0);
    @(negedge clk);
    applyStimulus(idle);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("post reset%0d retired", k), 32'(retired), 32'd0);
      checkOutput($sformatf("post reset%0d wb", k),      32'(act_wb),  32'd0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
